operand_read_return_stage: RTL and testbench

- Sits between the VRF bank read crossbar and the per-lane operand queues.
- Tracks per-queue credits (free data-buffer slots) so the operand requester issues a VRF read only when the target queue can absorb the result.
- Times the issued reads through the VRF read latency and registers returning read data, then presents it to each queue as operand/operand_valid.
- One instance per lane, covering all operand queues.

---
 rtl/operand_read_return_stage.sv | 113 +++++++++++
 tb/tb_operand_read_return_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_read_return_stage.sv
// Operand read-return stage: per-queue credit tracking toward the operand
// queues, a valid pipeline timing VRF reads through the bank read latency,
// and a registered operand/valid output toward each queue.
module operand_read_return_stage #(
  parameter int unsigned NrQueues    = 10,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned MaxCredits  = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NrQueues-1:0]                operand_issued_i,
  output logic [NrQueues-1:0]                credit_avail_o,
  input  logic [NrQueues-1:0][DataWidth-1:0] vrf_data_i,
  output logic [NrQueues-1:0][DataWidth-1:0] operand_o,
  output logic [NrQueues-1:0]                operand_valid_o,
  input  logic [NrQueues-1:0]                operand_pop_i,
  output logic [NrQueues-1:0][3:0]           credit_cnt_o,
  output logic                               err_overflow_o,
  output logic                               err_underflow_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxCredits);

  // Per-queue event flags gathered for the shared sticky error flags.
  logic [NrQueues-1:0] issue_bad;
  logic [NrQueues-1:0] pop_bad;

  logic err_ovf_reg, err_ovf_next;
  logic err_unf_reg, err_unf_next;

  genvar gi;
  generate
    for (gi = 0; gi < NrQueues; gi++) begin : g_queue
      logic [3:0]             cnt_reg, cnt_next;
      logic [ReadLatency-1:0] vpipe_reg, vpipe_next;
      logic [DataWidth-1:0]   op_reg, op_next;
      logic                   opv_reg, opv_next;
      logic                   issue_ok;
      logic                   pop_ok;
      logic                   rd_valid;

      // An issue is only honoured when a credit is available; a pop only
      // returns a credit when the counter is not already full. This keeps
      // the counter saturated in both directions without wrap-around.
      assign issue_ok       = operand_issued_i[gi] && (cnt_reg != 4'd0);
      assign pop_ok         = operand_pop_i[gi] && (cnt_reg != MaxCnt);
      assign issue_bad[gi]  = operand_issued_i[gi] && (cnt_reg == 4'd0);
      assign pop_bad[gi]    = operand_pop_i[gi] && (cnt_reg == MaxCnt);

      // Oldest pipeline stage lines up with the returning bank data.
      assign rd_valid = vpipe_reg[ReadLatency-1];

      // Shift accepted issues through ReadLatency stages.
      if (ReadLatency == 1) begin : g_lat1
        assign vpipe_next = issue_ok;
      end else begin : g_latn
        assign vpipe_next = {vpipe_reg[ReadLatency-2:0], issue_ok};
      end

      // Credit update and operand capture for this queue.
      always_comb begin
        cnt_next = cnt_reg - {3'b000, issue_ok} + {3'b000, pop_ok};
        opv_next = rd_valid;
        op_next  = op_reg;
        if (rd_valid) begin
          op_next = vrf_data_i[gi];
        end
      end

      // Per-queue state registers; reset drops any in-flight reads.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg   <= MaxCnt;
          vpipe_reg <= '0;
          op_reg    <= '0;
          opv_reg   <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          vpipe_reg <= vpipe_next;
          op_reg    <= op_next;
          opv_reg   <= opv_next;
        end
      end

      assign credit_cnt_o[gi]    = cnt_reg;
      assign credit_avail_o[gi]  = (cnt_reg != 4'd0);
      assign operand_o[gi]       = op_reg;
      assign operand_valid_o[gi] = opv_reg;
    end
  endgenerate

  // Sticky error flags: any illegal issue/pop in any queue latches until reset.
  always_comb begin
    err_ovf_next = err_ovf_reg | (|issue_bad);
    err_unf_next = err_unf_reg | (|pop_bad);
  end

  // Error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
    end else begin
      err_ovf_reg <= err_ovf_next;
      err_unf_reg <= err_unf_next;
    end
  end

  assign err_overflow_o  = err_ovf_reg;
  assign err_underflow_o = err_unf_reg;

endmodule

// File: tb/tb_operand_read_return_stage.sv
// Bench for operand_read_return_stage: two instances (ReadLatency 1 and 3)
// share one stimulus stream; a queue-based model predicts credits, error
// flags and the operand pulses, with literal expectations pinning the model.
module tb_operand_read_return_stage;

  localparam int NQ = 10;
  localparam int DW = 64;
  localparam int MC = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NQ-1:0]         iss;
  logic [NQ-1:0]         pop;
  logic [NQ-1:0][DW-1:0] vrf;

  logic [NQ-1:0]         avail_o [2];
  logic [NQ-1:0][DW-1:0] op_o    [2];
  logic [NQ-1:0]         valid_o [2];
  logic [NQ-1:0][3:0]    cnt_o   [2];
  logic                  ovf_o   [2];
  logic                  unf_o   [2];

  operand_read_return_stage #(
    .NrQueues(NQ), .DataWidth(DW), .ReadLatency(1), .MaxCredits(MC)
  ) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .operand_issued_i(iss), .credit_avail_o(avail_o[0]),
    .vrf_data_i(vrf), .operand_o(op_o[0]), .operand_valid_o(valid_o[0]),
    .operand_pop_i(pop), .credit_cnt_o(cnt_o[0]),
    .err_overflow_o(ovf_o[0]), .err_underflow_o(unf_o[0])
  );

  operand_read_return_stage #(
    .NrQueues(NQ), .DataWidth(DW), .ReadLatency(3), .MaxCredits(MC)
  ) dut_l3 (
    .clk_i(clk), .rst_i(rst),
    .operand_issued_i(iss), .credit_avail_o(avail_o[1]),
    .vrf_data_i(vrf), .operand_o(op_o[1]), .operand_valid_o(valid_o[1]),
    .operand_pop_i(pop), .credit_cnt_o(cnt_o[1]),
    .err_overflow_o(ovf_o[1]), .err_underflow_o(unf_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int                    cred [NQ];
  bit                    m_ovf, m_unf;
  logic [NQ-1:0]         ev  [2];
  logic [NQ-1:0][DW-1:0] eop [2];
  int                    due [2][NQ][$];   // cycles at which a pulse must appear
  int                    s = 0;            // current stimulus cycle
  bit                    chk_en = 0;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Drive one cycle of stimulus, advance the model, then wait past the edge.
  task automatic step(input logic [NQ-1:0] i_iss, input logic [NQ-1:0] i_pop,
                      input bit i_rst, input bit dead = 1'b0);
    int c0;
    @(negedge clk);
    iss = i_iss;
    pop = i_pop;
    rst = i_rst;
    for (int q = 0; q < NQ; q++) vrf[q] = 64'hA5A5_0000_0000_0000 | (64'(s) << 8) | 64'(q);
    if (dead) vrf[0] = 64'hDEAD;
    if (i_rst) begin
      m_ovf = 0;
      m_unf = 0;
      for (int k = 0; k < 2; k++) begin
        ev[k]  = '0;
        eop[k] = '0;
        for (int q = 0; q < NQ; q++) due[k][q].delete();
      end
      for (int q = 0; q < NQ; q++) cred[q] = MC;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int q = 0; q < NQ; q++) begin
          if (due[k][q].size() > 0 && due[k][q][0] == s + 1) begin
            void'(due[k][q].pop_front());
            ev[k][q]  = 1'b1;
            eop[k][q] = vrf[q];
          end else begin
            ev[k][q] = 1'b0;
          end
        end
      end
      for (int q = 0; q < NQ; q++) begin
        c0 = cred[q];
        if (i_iss[q]) begin
          if (c0 == 0) m_ovf = 1;
          else begin
            cred[q]--;
            for (int k = 0; k < 2; k++) due[k][q].push_back(s + lat(k) + 1);
          end
        end
        if (i_pop[q]) begin
          if (c0 == MC) m_unf = 1;
          else cred[q]++;
        end
      end
    end
    s++;
    chk_en = 1;
    @(posedge clk);
    #2;
  endtask

  // Compare both instances against the model every cycle.
  initial begin
    logic [NQ-1:0][3:0] exp_cnt;
    logic [NQ-1:0]      exp_av;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        for (int q = 0; q < NQ; q++) begin
          exp_cnt[q] = 4'(cred[q]);
          exp_av[q]  = (cred[q] != 0);
        end
        for (int k = 0; k < 2; k++) begin
          check($sformatf("cyc%0d_l%0d_cnt", s, lat(k)), 640'(cnt_o[k]), 640'(exp_cnt));
          check($sformatf("cyc%0d_l%0d_avail", s, lat(k)), 640'(avail_o[k]), 640'(exp_av));
          check($sformatf("cyc%0d_l%0d_errs", s, lat(k)), 640'({ovf_o[k], unf_o[k]}), 640'({m_ovf, m_unf}));
          check($sformatf("cyc%0d_l%0d_valid", s, lat(k)), 640'(valid_o[k]), 640'(ev[k]));
          check($sformatf("cyc%0d_l%0d_operand", s, lat(k)), 640'(op_o[k]), 640'(eop[k]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [NQ-1:0][3:0] all5;
    for (int q = 0; q < NQ; q++) all5[q] = 4'd5;
    rst = 1'b1;
    iss = '0;
    pop = '0;
    vrf = '0;

    // Reset state
    step('0, '0, 1);
    step('0, '0, 1);
    check("rst_cnt", 640'(cnt_o[0]), 640'(all5));
    check("rst_avail", 640'(avail_o[0]), 640'({NQ{1'b1}}));
    check("rst_valid", 640'(valid_o[0]), 640'(0));
    check("rst_operand", 640'(op_o[0]), 640'(0));
    check("rst_errs", 640'({ovf_o[0], unf_o[0]}), 640'(0));

    // Single issue on q0, data 0xDEAD one cycle later
    step(10'b1, '0, 0);
    check("t1_cnt0", 640'(cnt_o[0][0]), 640'(4));
    step('0, '0, 0, 1'b1);
    check("t2_valid0", 640'(valid_o[0][0]), 640'(1));
    check("t2_operand0", 640'(op_o[0][0]), 640'(64'hDEAD));
    step('0, 10'b1, 0);

    // Drain all credits on q3, then an illegal sixth issue
    repeat (5) step(10'(1 << 3), '0, 0);
    check("q3_avail_empty", 640'(avail_o[0][3]), 640'(0));
    check("q3_cnt_empty", 640'(cnt_o[0][3]), 640'(0));
    step(10'(1 << 3), '0, 0);
    check("q3_ovf", 640'(ovf_o[0]), 640'(1));
    repeat (4) step('0, '0, 0);
    check("q3_ovf_sticky", 640'(ovf_o[1]), 640'(1));
    // Issue+pop at cnt 0: issue dropped, pop counted
    step(10'(1 << 3), 10'(1 << 3), 0);
    check("q3_issue_pop_cnt", 640'(cnt_o[0][3]), 640'(1));
    check("q3_issue_pop_ovf", 640'(ovf_o[0]), 640'(1));

    // q5 at cnt 4: simultaneous issue and pop keeps the count
    step(10'(1 << 5), '0, 0);
    step(10'(1 << 5), 10'(1 << 5), 0);
    check("q5_cnt_hold", 640'(cnt_o[0][5]), 640'(4));
    step('0, '0, 0);
    check("q5_pulse_l1", 640'(valid_o[0][5]), 640'(1));

    // Pop on full q7
    step('0, 10'(1 << 7), 0);
    check("q7_cnt_full", 640'(cnt_o[0][7]), 640'(5));
    check("q7_unf", 640'(unf_o[0]), 640'(1));
    check("q7_other_q0", 640'(cnt_o[0][0]), 640'(5));

    // Mixed deterministic traffic across all queues
    for (int i = 0; i < 30; i++) begin
      step(10'((i * 113 + 5) % 1024), 10'((i * 59 + 7) % 1024), 0);
    end
    repeat (5) step('0, '0, 0);

    // Reset mid-flight on the ReadLatency=3 instance
    step('0, '0, 1);
    step('0, '0, 1);
    check("rst2_errs_l3", 640'({ovf_o[1], unf_o[1]}), 640'(0));
    step(10'b1, '0, 0);
    check("rst2_cnt0_l3", 640'(cnt_o[1][0]), 640'(4));
    step('0, '0, 0);
    step('0, '0, 1);
    check("rst2_cnt_all5", 640'(cnt_o[1]), 640'(all5));
    check("rst2_errs_after", 640'({ovf_o[1], unf_o[1]}), 640'(0));
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 0);
      check($sformatf("rst2_no_pulse_%0d", i), 640'(valid_o[1]), 640'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
